// File: rtl/utf8_decoder_pkg.sv
// Shared constants for the UTF-8 decoder: FSM states, byte classes, code point limits
// and the completion validity check.
package utf8_decoder_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NEED1 = 2'd1,
        ST_NEED2 = 2'd2,
        ST_NEED3 = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_ASCII   = 3'd0,
        CLS_LEAD2   = 3'd1,
        CLS_LEAD3   = 3'd2,
        CLS_LEAD4   = 3'd3,
        CLS_CONT    = 3'd4,
        CLS_INVALID = 3'd5
    } byte_class_t;

    localparam logic [20:0] CP_MIN_LEN2 = 21'h000080;
    localparam logic [20:0] CP_MIN_LEN3 = 21'h000800;
    localparam logic [20:0] CP_MIN_LEN4 = 21'h010000;
    localparam logic [20:0] CP_MAX      = 21'h10FFFF;
    localparam logic [20:0] CP_SURR_LO  = 21'h00D800;
    localparam logic [20:0] CP_SURR_HI  = 21'h00DFFF;

    // True when a completed sequence is overlong, a surrogate or beyond the Unicode range.
    function automatic logic cp_invalid(input logic [20:0] cp, input logic [2:0] len);
        return ((len == 3'd2) && (cp < CP_MIN_LEN2)) ||
               ((len == 3'd3) && (cp < CP_MIN_LEN3)) ||
               ((len == 3'd4) && (cp < CP_MIN_LEN4)) ||
               ((cp >= CP_SURR_LO) && (cp <= CP_SURR_HI)) ||
               (cp > CP_MAX);
    endfunction

endpackage

// File: rtl/utf8_byte_classifier.sv
// Combinational UTF-8 byte classifier: class code plus the payload bits a lead byte
// (or ASCII byte) contributes to the code point.
module utf8_byte_classifier
    import utf8_decoder_pkg::*;
(
    input  logic [7:0]  in_byte,
    output byte_class_t byte_class,
    output logic [6:0]  payload
);

    // Decode the byte's prefix; C0/C1 and F5-FF can never start a valid sequence.
    always_comb begin
        byte_class = CLS_INVALID;
        payload    = 7'd0;
        if (in_byte[7] == 1'b0) begin
            byte_class = CLS_ASCII;
            payload    = in_byte[6:0];
        end else if (in_byte[7:6] == 2'b10) begin
            byte_class = CLS_CONT;
            payload    = {1'b0, in_byte[5:0]};
        end else if ((in_byte >= 8'hC2) && (in_byte <= 8'hDF)) begin
            byte_class = CLS_LEAD2;
            payload    = {2'b00, in_byte[4:0]};
        end else if ((in_byte >= 8'hE0) && (in_byte <= 8'hEF)) begin
            byte_class = CLS_LEAD3;
            payload    = {3'b000, in_byte[3:0]};
        end else if ((in_byte >= 8'hF0) && (in_byte <= 8'hF4)) begin
            byte_class = CLS_LEAD4;
            payload    = {4'b0000, in_byte[2:0]};
        end else begin
            byte_class = CLS_INVALID;
            payload    = 7'd0;
        end
    end

endmodule

// File: rtl/utf8_decoder.sv
// UTF-8 byte stream to code point decoder with one-byte input register, backpressure
// toward the byte FIFO and replacement-character substitution for malformed input.
module utf8_decoder
    import utf8_decoder_pkg::*;
#(
    parameter logic [20:0] REPLACEMENT_CHAR = 21'h00FFFD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_data_available,
    output logic        ready,
    output logic [20:0] out_data,
    output logic        out_data_available,
    input  logic        out_receiver_ready,
    output logic        decode_error
);

    logic [7:0]  byte_q;
    logic        byte_valid;
    state_t      state;
    // Before the final continuation byte at most 3+6+6 payload bits are held.
    logic [14:0] acc;
    logic [2:0]  len;

    byte_class_t byte_class;
    logic [6:0]  payload;

    state_t      state_next;
    logic [14:0] acc_next;
    logic [2:0]  len_next;
    logic        want_emit;
    logic        emit_consumes;
    logic        advance;
    logic [20:0] emit_value;
    logic        emit_error;
    logic        slot_free;
    logic        load;
    logic        consume;
    logic [20:0] acc_cat;

    utf8_byte_classifier u_classifier (
        .in_byte    (byte_q),
        .byte_class (byte_class),
        .payload    (payload)
    );

    assign ready     = ~byte_valid;
    assign acc_cat   = {acc, byte_q[5:0]};
    assign slot_free = ~out_data_available | out_receiver_ready;
    assign load      = want_emit & slot_free;
    assign consume   = advance | (load & emit_consumes);

    // Next-state decode for the byte sitting in byte_q.
    always_comb begin
        state_next    = state;
        acc_next      = acc;
        len_next      = len;
        want_emit     = FALSE;
        emit_consumes = FALSE;
        advance       = FALSE;
        emit_value    = 21'd0;
        emit_error    = FALSE;
        if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    case (byte_class)
                        CLS_ASCII: begin
                            want_emit     = TRUE;
                            emit_consumes = TRUE;
                            emit_value    = {14'd0, payload};
                        end
                        CLS_LEAD2: begin
                            advance    = TRUE;
                            acc_next   = {8'd0, payload};
                            len_next   = 3'd2;
                            state_next = ST_NEED1;
                        end
                        CLS_LEAD3: begin
                            advance    = TRUE;
                            acc_next   = {8'd0, payload};
                            len_next   = 3'd3;
                            state_next = ST_NEED2;
                        end
                        CLS_LEAD4: begin
                            advance    = TRUE;
                            acc_next   = {8'd0, payload};
                            len_next   = 3'd4;
                            state_next = ST_NEED3;
                        end
                        default: begin
                            want_emit     = TRUE;
                            emit_consumes = TRUE;
                            emit_value    = REPLACEMENT_CHAR;
                            emit_error    = TRUE;
                        end
                    endcase
                end
                ST_NEED3, ST_NEED2: begin
                    if (byte_class == CLS_CONT) begin
                        advance    = TRUE;
                        acc_next   = acc_cat[14:0];
                        state_next = (state == ST_NEED3) ? ST_NEED2 : ST_NEED1;
                    end else begin
                        // Interrupted sequence: byte stays in byte_q for reprocessing.
                        want_emit  = TRUE;
                        emit_value = REPLACEMENT_CHAR;
                        emit_error = TRUE;
                        acc_next   = 15'd0;
                        state_next = ST_IDLE;
                    end
                end
                ST_NEED1: begin
                    want_emit  = TRUE;
                    acc_next   = 15'd0;
                    state_next = ST_IDLE;
                    if (byte_class == CLS_CONT) begin
                        emit_consumes = TRUE;
                        emit_error    = cp_invalid(acc_cat, len);
                        emit_value    = emit_error ? REPLACEMENT_CHAR : acc_cat;
                    end else begin
                        emit_value = REPLACEMENT_CHAR;
                        emit_error = TRUE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    acc_next   = 15'd0;
                    advance    = TRUE;
                end
            endcase
        end else begin
            state_next = state;
        end
    end

    // Input byte register; a strobe while a byte is held is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_q     <= 8'd0;
            byte_valid <= FALSE;
        end else if (byte_valid) begin
            if (consume) begin
                byte_valid <= FALSE;
            end
        end else if (in_data_available) begin
            byte_q     <= in_data;
            byte_valid <= TRUE;
        end
    end

    // Sequence FSM and accumulator; frozen while an emission waits for the output slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= 15'd0;
            len   <= 3'd0;
        end else if (advance || load) begin
            state <= state_next;
            acc   <= acc_next;
            len   <= len_next;
        end
    end

    // Output slot: load new code point, otherwise clear on transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data           <= 21'd0;
            out_data_available <= FALSE;
            decode_error       <= FALSE;
        end else if (load) begin
            out_data           <= emit_value;
            out_data_available <= TRUE;
            decode_error       <= emit_error;
        end else begin
            decode_error <= FALSE;
            if (out_data_available && out_receiver_ready) begin
                out_data_available <= FALSE;
            end
        end
    end

endmodule

// File: doc/utf8_decoder.md
Name: utf8_decoder

Overview:
- Byte-to-code-point stage directly downstream of the terminal input byte FIFO.
- Takes the FIFO's one-cycle byte pulses, reassembles UTF-8 sequences and presents one Unicode code point at a time to the terminal stream decoder.
- Applies backpressure through the FIFO's receiver_ready input.
- Substitutes a replacement character for any malformed input.

Parameters:
- REPLACEMENT_CHAR, 21'h00FFFD: code point emitted for malformed, overlong, surrogate or out-of-range sequences.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_data  input  8  byte from the FIFO (FIFO out_data)
- in_data_available  input  1  one-cycle byte strobe (FIFO out_data_available)
- ready  output  1  to FIFO receiver_ready; high when a new byte may be requested
- out_data  output  21  decoded code point
- out_data_available  output  1  code point valid; held until accepted
- out_receiver_ready  input  1  downstream accepts; transfer occurs on any cycle where out_data_available and out_receiver_ready are both high
- decode_error  output  1  one-cycle pulse each time REPLACEMENT_CHAR is loaded into out_data

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: out_data = 0, out_data_available = 0, decode_error = 0, ready = 1, byte register empty, FSM in IDLE, accumulator = 0.
- Byte register (byte_q/byte_valid):
  - Loaded on in_data_available.
  - ready = !byte_valid, taken straight from the register. The FIFO alternates emit/idle cycles, so no byte can arrive while byte_valid = 1.
  - A strobe that arrives while byte_valid = 1 is dropped, and state is unchanged.
- Byte consumption: the byte in byte_q is consumed on a cycle when one of these holds:
  - it does not complete an output, or
  - the output slot is free (out_data_available = 0, or out_receiver_ready = 1).
  - Otherwise it stays in byte_q and ready stays low.
- Latency: strobe at cycle N, byte_q valid at N+1, out_data_available high at N+2 for a completing byte with a free slot.
- FSM states: IDLE, NEED1, NEED2, NEED3. NEEDk = k continuation bytes still expected. Lead bytes in IDLE:
  - 0x00-0x7F: emit {13'b0, byte}; stay in IDLE.
  - 0xC2-0xDF: acc = byte[4:0]; go to NEED1; len = 2.
  - 0xE0-0xEF: acc = byte[3:0]; go to NEED2; len = 3.
  - 0xF0-0xF4: acc = byte[2:0]; go to NEED3; len = 4.
  - 0x80-0xBF (stray continuation), 0xC0, 0xC1, 0xF5-0xFF: emit REPLACEMENT_CHAR; stay in IDLE.
- In NEEDk, continuation byte (10xxxxxx): acc = {acc, byte[5:0]}, truncated to 21 bits.
  - k > 1: go to NEED(k-1); no output.
  - k = 1: validate, emit, return to IDLE.
- In NEEDk, non-continuation byte: emit REPLACEMENT_CHAR and return to IDLE.
  - The byte is NOT consumed; it stays in byte_q and is reprocessed as a lead byte on the next eligible cycle.
  - Result: two outputs, in order.
- Validation at completion: substitute REPLACEMENT_CHAR if any of the following is true:
  - len = 2 and cp < 0x80
  - len = 3 and cp < 0x800
  - len = 4 and cp < 0x10000
  - 0xD800 <= cp <= 0xDFFF
  - cp > 0x10FFFF
- Emission:
  - Load out_data, set out_data_available = 1.
  - Pulse decode_error if and only if the value is the substitution.
  - out_data_available clears on transfer unless a new code point is loaded in the same cycle; back-to-back outputs are allowed.
- Output stability: out_data and out_data_available stay stable while out_data_available = 1 and out_receiver_ready = 0.
- Reset mid-sequence: the partial sequence is discarded silently (no REPLACEMENT_CHAR); the pending output and byte_q are cleared.

Decomposition:
- Shared constant include (alongside TRUE/FALSE):
  - UTF-8 FSM state encodings (IDLE, NEED1, NEED2, NEED3).
  - Lead-byte class codes (ASCII, LEAD2, LEAD3, LEAD4, CONT, INVALID).
  - Code point limits 0x80, 0x800, 0x10000, 0x10FFFF, 0xD800, 0xDFFF.
- Sub-module utf8_byte_classifier (combinational):
  - Input: byte.
  - Outputs: class code and initial payload bits.
  - Instantiated once.

Test Plan:
- ASCII: strobe 0x41 at cycle N, out_receiver_ready = 1 -> out_data = 0x000041, out_data_available at N+2 for exactly 1 cycle, decode_error = 0, ready low only at N+1.
- Multi-byte: C3 A9 -> 0x0000E9; E2 82 AC -> 0x0020AC; F0 9F 98 80 -> 0x01F600; one output each, none mid-sequence.
- Truncation: E2 82 41 -> REPLACEMENT_CHAR with decode_error pulse, then 0x000041; exactly two outputs.
- Invalid forms:
  - C0 AF -> REPLACEMENT_CHAR twice.
  - ED A0 80 (surrogate) -> one REPLACEMENT_CHAR.
  - F4 90 80 80 (> 0x10FFFF) -> one REPLACEMENT_CHAR.
  - E0 80 80 (overlong) -> one REPLACEMENT_CHAR.
- Backpressure:
  - out_receiver_ready = 0 while sending 0x41 then 0x42 -> out_data holds 0x41; ready stays low after 0x42 is latched.
  - Release -> 0x41 then 0x42 in order; no loss.
- Reset mid-sequence: F0 9F, reset 1 cycle, then 0x41 -> only 0x000041 emitted; no decode_error pulse.
